// File: rtl/sdram_pattern_tester.sv
// Pattern writer/checker on the SDRAM controller host port: fills a range, reads it back, counts mismatches.
// Define SDRAM_TESTER_LFSR_PATTERN_EN for LFSR data; otherwise data is the address XOR 16'h5A5A.
module sdram_pattern_tester #(
  parameter logic [21:0] ADDR_FIRST = 22'h000000,
  parameter logic [21:0] ADDR_LAST  = 22'h3FFFFF,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        start,
  output logic [21:0] sys_addr,
  output logic [15:0] sys_data_to_sdram,
  output logic        sys_write_rq,
  output logic        sys_read_rq,
  input  logic        sys_write_done,
  input  logic [15:0] sys_data_from_sdram,
  input  logic        sys_data_from_sdram_valid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [15:0] error_count,
  output logic [21:0] first_err_addr,
  output logic [2:0]  state_
);

  localparam int WDOG_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR_REQ = 3'd1,
    WR_GAP = 3'd2,
    RD_REQ = 3'd3,
    RD_GAP = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [21:0]       addr_q, addr_d;
  logic [15:0]       pattern_q, pattern_d;
  logic              wr_rq_q, wr_rq_d;
  logic              rd_rq_q, rd_rq_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic [21:0]       first_err_q, first_err_d;
  logic              timeout_q, timeout_d;
  logic              pass_q, pass_d;

  logic [21:0]       addr_inc;
  logic [15:0]       seed_pattern;
  logic [15:0]       next_pattern;

  assign addr_inc = addr_q + 22'd1;

`ifdef SDRAM_TESTER_LFSR_PATTERN_EN
  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting right with feedback into bit 15.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  assign seed_pattern = 16'hACE1;
  assign next_pattern = lfsr_step(pattern_q);
`else
  assign seed_pattern = ADDR_FIRST[15:0] ^ 16'h5A5A;
  assign next_pattern = addr_inc[15:0] ^ 16'h5A5A;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    pattern_d   = pattern_q;
    wdog_d      = '0;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    timeout_d   = timeout_q;
    pass_d      = pass_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          err_cnt_d   = '0;
          first_err_d = '0;
          timeout_d   = 1'b0;
          pass_d      = 1'b0;
          addr_d      = ADDR_FIRST;
          pattern_d   = seed_pattern;
          state_d     = WR_REQ;
        end
      end
      WR_REQ: begin
        if (sys_write_done) begin
          state_d = WR_GAP;
        end else if (wdog_q == WDOG_LAST) begin
          timeout_d = 1'b1;
          pass_d    = 1'b0;
          state_d   = DONE;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
      end
      WR_GAP: begin
        if (addr_q == ADDR_LAST) begin
          addr_d    = ADDR_FIRST;
          pattern_d = seed_pattern;
          state_d   = RD_REQ;
        end else begin
          addr_d    = addr_inc;
          pattern_d = next_pattern;
          state_d   = WR_REQ;
        end
      end
      RD_REQ: begin
        if (sys_data_from_sdram_valid) begin
          if (sys_data_from_sdram != pattern_q) begin
            if (err_cnt_q != 16'hFFFF) begin
              err_cnt_d = err_cnt_q + 16'd1;
            end
            if (err_cnt_q == 16'd0) begin
              first_err_d = addr_q;
            end
          end
          state_d = RD_GAP;
        end else if (wdog_q == WDOG_LAST) begin
          timeout_d = 1'b1;
          pass_d    = 1'b0;
          state_d   = DONE;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
      end
      RD_GAP: begin
        if (addr_q == ADDR_LAST) begin
          pass_d  = (err_cnt_q == 16'd0) && !timeout_q;
          state_d = DONE;
        end else begin
          addr_d    = addr_inc;
          pattern_d = next_pattern;
          state_d   = RD_REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    wr_rq_d = (state_d == WR_REQ);
    rd_rq_d = (state_d == RD_REQ);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      pattern_q   <= '0;
      wr_rq_q     <= 1'b0;
      rd_rq_q     <= 1'b0;
      wdog_q      <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      timeout_q   <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      pattern_q   <= pattern_d;
      wr_rq_q     <= wr_rq_d;
      rd_rq_q     <= rd_rq_d;
      wdog_q      <= wdog_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      timeout_q   <= timeout_d;
      pass_q      <= pass_d;
    end
  end

  // Masking with the acknowledge keeps the controller from seeing a stale request after it answers.
  assign sys_write_rq      = wr_rq_q & ~sys_write_done;
  assign sys_read_rq       = rd_rq_q & ~sys_data_from_sdram_valid;
  assign sys_addr          = addr_q;
  assign sys_data_to_sdram = pattern_q;
  assign busy              = (state_q != IDLE) && (state_q != DONE);
  assign done              = (state_q == DONE);
  assign pass              = pass_q;
  assign timeout           = timeout_q;
  assign error_count       = err_cnt_q;
  assign first_err_addr    = first_err_q;
  assign state_            = state_q;

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Scoreboard bench for sdram_pattern_tester: an ideal controller model plus a single-address instance.
module tb_sdram_pattern_tester;

  localparam logic [21:0] FIRST    = 22'd0;
  localparam logic [21:0] LAST     = 22'd15;
  localparam logic [21:0] ONE_ADDR = 22'h3FFFFF;

`ifdef SDRAM_TESTER_LFSR_PATTERN_EN
  localparam bit LFSR_MODE = 1'b1;
`else
  localparam bit LFSR_MODE = 1'b0;
`endif

  typedef struct packed {
    logic        pass;
    logic        tmo;
    logic [15:0] errs;
    logic [21:0] first;
    logic [7:0]  wr_cnt;
    logic [7:0]  rd_cnt;
    logic [7:0]  run_max;
    logic [7:0]  proto;
  } res_t;

  localparam res_t RES_OK = '{pass: 1'b1, tmo: 1'b0, errs: 16'd0, first: 22'd0,
                              wr_cnt: 8'd16, rd_cnt: 8'd16, run_max: 8'd2, proto: 8'd0};
  localparam res_t RES_BAD = '{pass: 1'b0, tmo: 1'b0, errs: 16'd2, first: 22'd5,
                               wr_cnt: 8'd16, rd_cnt: 8'd16, run_max: 8'd2, proto: 8'd0};
  localparam res_t RES_TMO = '{pass: 1'b0, tmo: 1'b1, errs: 16'd0, first: 22'd0,
                               wr_cnt: 8'd1, rd_cnt: 8'd0, run_max: 8'd20, proto: 8'd0};

  logic        clk;
  logic        rst;
  logic        start;
  logic [21:0] sys_addr;
  logic [15:0] sys_data_to_sdram;
  logic        sys_write_rq;
  logic        sys_read_rq;
  logic        wr_done;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [15:0] error_count;
  logic [21:0] first_err_addr;
  logic [2:0]  state_;

  logic        one_start;
  logic [21:0] one_addr;
  logic [15:0] one_data;
  logic        one_write_rq;
  logic        one_read_rq;
  logic        one_wr_done;
  logic [15:0] one_rd_data;
  logic        one_rd_valid;
  logic        one_busy;
  logic        one_done;
  logic        one_pass;
  logic        one_timeout;
  logic [15:0] one_error_count;
  logic [21:0] one_first_err_addr;
  logic [2:0]  one_state;

  int          vectors;
  int          miscompares;
  bit          corrupt_en;
  bit          never_ack;
  logic [15:0] mem [16];
  logic [37:0] exp_wr_q [$];
  res_t        exp_res_q [$];

  sdram_pattern_tester #(.ADDR_FIRST(FIRST), .ADDR_LAST(LAST), .TIMEOUT(20)) u_dut (
    .sys_clk                   (clk),
    .sys_rst                   (rst),
    .start                     (start),
    .sys_addr                  (sys_addr),
    .sys_data_to_sdram         (sys_data_to_sdram),
    .sys_write_rq              (sys_write_rq),
    .sys_read_rq               (sys_read_rq),
    .sys_write_done            (wr_done),
    .sys_data_from_sdram       (rd_data),
    .sys_data_from_sdram_valid (rd_valid),
    .busy                      (busy),
    .done                      (done),
    .pass                      (pass),
    .timeout                   (timeout),
    .error_count               (error_count),
    .first_err_addr            (first_err_addr),
    .state_                    (state_)
  );

  sdram_pattern_tester #(.ADDR_FIRST(ONE_ADDR), .ADDR_LAST(ONE_ADDR), .TIMEOUT(20)) u_one (
    .sys_clk                   (clk),
    .sys_rst                   (rst),
    .start                     (one_start),
    .sys_addr                  (one_addr),
    .sys_data_to_sdram         (one_data),
    .sys_write_rq              (one_write_rq),
    .sys_read_rq               (one_read_rq),
    .sys_write_done            (one_wr_done),
    .sys_data_from_sdram       (one_rd_data),
    .sys_data_from_sdram_valid (one_rd_valid),
    .busy                      (one_busy),
    .done                      (one_done),
    .pass                      (one_pass),
    .timeout                   (one_timeout),
    .error_count               (one_error_count),
    .first_err_addr            (one_first_err_addr),
    .state_                    (one_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] patFor(input logic [21:0] base, input int idx);
    logic [15:0] v;
    v = 16'hACE1;
    for (int k = 0; k < idx; k++) v = {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    return LFSR_MODE ? v : (16'(base + 22'(idx)) ^ 16'h5A5A);
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic reportUnexpected(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: got an output event, expected none queued", name);
  endtask

  // Controller model and monitor: acks 3 cycles after a request, then checks the handshake and scoreboard.
  initial begin
    bit          prev_wr, prev_rd, prev_done, was_ack, req_now;
    int          wait_cnt, run, run_max, wr_cnt, rd_cnt, proto;
    logic [37:0] e;
    res_t        r;
    prev_wr = 0; prev_rd = 0; prev_done = 0;
    wait_cnt = 0; run = 0; run_max = 0; wr_cnt = 0; rd_cnt = 0; proto = 0;
    wr_done = 1'b0;
    rd_valid = 1'b0;
    rd_data = 16'd0;
    forever begin
      @(negedge clk);
      req_now = sys_write_rq || sys_read_rq;
      was_ack = wr_done || rd_valid;
      wr_done = 1'b0;
      rd_valid = 1'b0;
      if (rst || !req_now || never_ack) begin
        wait_cnt = 0;
      end else begin
        wait_cnt++;
        if (wait_cnt == 3) begin
          wait_cnt = 0;
          if (sys_write_rq) begin
            mem[sys_addr[3:0]] = sys_data_to_sdram;
            wr_done = 1'b1;
          end else begin
            rd_data = mem[sys_addr[3:0]] ^
                      ((corrupt_en && (sys_addr == 22'd5 || sys_addr == 22'd9)) ? 16'h0001 : 16'h0000);
            rd_valid = 1'b1;
          end
        end
      end
      #1;
      if (start) begin
        wr_cnt = 0; rd_cnt = 0; run_max = 0; proto = 0;
      end
      if ((wr_done && sys_write_rq) || (rd_valid && sys_read_rq) ||
          (was_ack && (sys_write_rq || sys_read_rq))) proto++;
      if (sys_write_rq && !prev_wr) begin
        wr_cnt++;
        if (exp_wr_q.size() == 0) reportUnexpected("wr_request");
        else begin
          e = exp_wr_q.pop_front();
          checkOutput("wr_addr_data", 128'({sys_addr, sys_data_to_sdram}), 128'(e));
        end
      end
      if (sys_read_rq && !prev_rd) rd_cnt++;
      run = (sys_write_rq || sys_read_rq) ? run + 1 : 0;
      if (run > run_max) run_max = run;
      if (done && !prev_done) begin
        if (exp_res_q.size() == 0) reportUnexpected("done");
        else begin
          r = exp_res_q.pop_front();
          checkOutput("res_pass", 128'(pass), 128'(r.pass));
          checkOutput("res_timeout", 128'(timeout), 128'(r.tmo));
          checkOutput("res_error_count", 128'(error_count), 128'(r.errs));
          checkOutput("res_first_err_addr", 128'(first_err_addr), 128'(r.first));
          checkOutput("res_busy_low", 128'(busy), 128'(0));
          checkOutput("res_write_requests", 128'(wr_cnt), 128'(r.wr_cnt));
          checkOutput("res_read_requests", 128'(rd_cnt), 128'(r.rd_cnt));
          checkOutput("res_longest_request", 128'(run_max), 128'(r.run_max));
          checkOutput("res_handshake_violations", 128'(proto), 128'(r.proto));
        end
      end
      prev_wr = sys_write_rq;
      prev_rd = sys_read_rq;
      prev_done = done;
    end
  end

  task automatic waitDone(input string tag);
    int n;
    n = 0;
    while (!done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_done_reached"}, 128'(done), 128'(1));
  endtask

  task automatic applyStimulus(input string tag, input bit corrupt, input bit noack,
                               input res_t exp, input int n_writes);
    corrupt_en = corrupt;
    never_ack  = noack;
    for (int i = 0; i < n_writes; i++)
      exp_wr_q.push_back({FIRST + 22'(i), patFor(FIRST, i)});
    exp_res_q.push_back(exp);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(tag);
    @(negedge clk);
    @(negedge clk);
    never_ack = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL global_time_limit: got no end of test, expected completion");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    int n;
    vectors = 0;
    miscompares = 0;
    corrupt_en = 1'b0;
    never_ack = 1'b0;
    rst = 1'b1;
    start = 1'b0;
    one_start = 1'b0;
    one_wr_done = 1'b0;
    one_rd_valid = 1'b0;
    one_rd_data = 16'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs",
                128'({sys_addr, sys_data_to_sdram, sys_write_rq, sys_read_rq, busy, done, pass,
                      timeout, error_count, first_err_addr, state_}), 128'(0));
    checkOutput("reset_outputs_one",
                128'({one_addr, one_data, one_write_rq, one_read_rq, one_busy, one_done, one_pass,
                      one_timeout, one_error_count, one_first_err_addr, one_state}), 128'(0));
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] clean run over 0..15");
    applyStimulus("clean", 1'b0, 1'b0, RES_OK, 16);
    $display("[TB] corrupted reads at 5 and 9");
    applyStimulus("corrupt", 1'b1, 1'b0, RES_BAD, 16);
    $display("[TB] controller never acknowledges");
    applyStimulus("timeout", 1'b0, 1'b1, RES_TMO, 1);

    $display("[TB] reset during read pass");
    corrupt_en = 1'b0;
    for (int i = 0; i < 16; i++) exp_wr_q.push_back({FIRST + 22'(i), patFor(FIRST, i)});
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(state_ == 3'd3 && sys_addr == 22'd7) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rd7_reached", 128'({state_, sys_addr}), 128'({3'd3, 22'd7}));
    rst = 1'b1;
    @(negedge clk);
    checkOutput("reset_mid_outputs",
                128'({sys_addr, sys_data_to_sdram, sys_write_rq, sys_read_rq, busy, done, pass,
                      timeout, error_count, first_err_addr, state_}), 128'(0));
    rst = 1'b0;
    @(negedge clk);
    applyStimulus("rerun", 1'b0, 1'b0, RES_OK, 16);

    $display("[TB] single address with start pulses while busy");
    @(negedge clk);
    one_start = 1'b1;
    @(negedge clk);
    one_start = 1'b0;
    checkOutput("one_write_req", 128'({one_write_rq, one_busy, one_addr, one_data}),
                128'({1'b1, 1'b1, ONE_ADDR, patFor(ONE_ADDR, 0)}));
    one_start = 1'b1;
    @(negedge clk);
    one_start = 1'b0;
    one_wr_done = 1'b1;
    #1;
    checkOutput("one_write_masked", 128'(one_write_rq), 128'(0));
    @(negedge clk);
    one_wr_done = 1'b0;
    checkOutput("one_write_gap", 128'({one_write_rq, one_read_rq, one_state}), 128'({1'b0, 1'b0, 3'd2}));
    @(negedge clk);
    checkOutput("one_read_req", 128'({one_read_rq, one_addr, one_state}), 128'({1'b1, ONE_ADDR, 3'd3}));
    one_start = 1'b1;
    @(negedge clk);
    one_start = 1'b0;
    checkOutput("one_start_ignored", 128'({one_read_rq, one_write_rq, one_state}),
                128'({1'b1, 1'b0, 3'd3}));
    one_rd_data = patFor(ONE_ADDR, 0);
    one_rd_valid = 1'b1;
    @(negedge clk);
    one_rd_valid = 1'b0;
    n = 0;
    while (!one_done && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("one_result", 128'({one_done, one_pass, one_timeout, one_error_count, one_busy}),
                128'({1'b1, 1'b1, 1'b0, 16'd0, 1'b0}));
    repeat (5) @(negedge clk);
    checkOutput("one_quiet_after_done", 128'({one_write_rq, one_read_rq, one_state}),
                128'({1'b0, 1'b0, 3'd5}));

    checkOutput("wr_queue_drained", 128'(exp_wr_q.size()), 128'(0));
    checkOutput("res_queue_drained", 128'(exp_res_q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
